cmn_rand_victim_sel: RTL
========================

// Module: cmn_rand_victim_sel
// PURPOSE
//  Random-replacement victim picker for set-associative arrays (TLB, BTB, small caches).
//  Consumes the 4-bit value from the common LFSR as a random start way.
//  Scans round-robin from that way for the first eligible way:
//  invalid+unlocked ways first, else any unlocked way.
//  Sits between the LFSR and the array fill/replace control; req/rsp valid-ready handshakes.
// PARAMETERS
//  WAYS  8             number of ways; power of two, 2..16
//  IDXW  $clog2(WAYS)  way-index width (derived, do not override)
// PORTS
//  clk         in   1     clock
//  rst         in   1     reset
//  rand_i      in   4     LFSR value; only bits [IDXW-1:0] are used
//  req_vld     in   1     victim request valid
//  req_rdy     out  1     request accepted when req_vld & req_rdy
//  valid_mask  in   WAYS  per-way valid bits of the indexed set (sampled at accept)
//  lock_mask   in   WAYS  per-way lock/pinned bits (sampled at accept)
//  rsp_vld     out  1     victim response valid
//  rsp_rdy     in   1     response consumed when rsp_vld & rsp_rdy
//  rsp_way     out  IDXW  selected victim way
//  rsp_inv     out  1     selected way was invalid (fill, no eviction)
//  rsp_none    out  1     all ways locked; rsp_way = 0, no victim
// BEHAVIOUR
//  - Clocking/reset: one clock; reset is asynchronous and active-high.
//  - Reset values: state=IDLE, req_rdy=1, rsp_vld=0, rsp_way=0, rsp_inv=0, rsp_none=0, ptr=0.
//  - FSM states: IDLE, SCAN, RESP.
//  - req_rdy = (state==IDLE); one request in flight at a time.
//  - Accept, cycle T:
//    - Register cand = (~valid_mask & ~lock_mask) != 0 ? ~valid_mask & ~lock_mask : ~lock_mask.
//    - Register inv_sel = (first term nonzero).
//    - Register ptr = rand_i[IDXW-1:0].
//  - IDLE->RESP at accept when ~lock_mask==0.
//    - rsp_none=1, rsp_way=0, rsp_inv=0; rsp_vld rises at T+1.
//  - IDLE->SCAN at accept otherwise.
//  - SCAN: test one way per cycle.
//    - If cand[ptr]: rsp_way<=ptr, rsp_inv<=inv_sel, rsp_none<=0, go RESP.
//    - Else ptr <= ptr+1 mod WAYS (wraps WAYS-1 -> 0).
//    - Response latency: rsp_vld at T+2+d, where d = (way - start) mod WAYS; max T+WAYS+1.
//  - RESP: rsp_vld=1; rsp_way/rsp_inv/rsp_none held stable until rsp_rdy.
//    - On rsp_vld & rsp_rdy: go IDLE and clear rsp_vld.
//    - Next accept no earlier than the following cycle.
//  - Masks and rand_i are ignored outside the accept cycle; changes mid-scan have no effect.
//  - rsp_rdy may be held low indefinitely: no drop, no change of response.
//  - Reset mid-operation: immediate return to reset values; the pending request is lost.
//  - rand_i bits above IDXW are ignored; rand_i is never written by this block.
// STRUCTURE
//  - Package cmn_rand_pkg:
//    - victim_state_e enum {IDLE, SCAN, RESP}.
//    - function cand_mask(valid, lock) returning {inv_sel, cand}.
//  - No sub-module: single FSM + ptr counter + response register.
//  - The LFSR is instantiated by the parent and wired to rand_i.
// TESTING (WAYS=8)
//  1. valid=8'hFF, lock=0, rand=4'h5, accept T
//     -> rsp_way=5, rsp_inv=0, rsp_vld at T+2.
//  2. valid=8'hBF, lock=0, rand=4'h2
//     -> scan 2..6, rsp_way=6, rsp_inv=1, rsp_vld at T+6.
//  3. lock=8'hFF, any valid/rand
//     -> rsp_none=1, rsp_way=0, rsp_vld at T+1; req_rdy low until rsp handshake.
//  4. Wrap: valid=8'hFF, lock=8'hFC, rand=4'hE (start 6)
//     -> scan 6,7,0, rsp_way=0, rsp_vld at T+4.
//  5. Backpressure: case 1 with rsp_rdy low 5 cycles and masks changed mid-scan
//     -> response unchanged, req_rdy=0; IDLE the cycle after rsp_rdy=1.
//  6. Assert rst during SCAN of case 2
//     -> all outputs return to reset values immediately; req_rdy=1 after release.

Source files
------------

// File: rtl/cmn_rand_pkg.sv
// Shared types and helpers for the random-replacement victim selector.
package cmn_rand_pkg;

  localparam int unsigned MAX_WAYS = 16;
  localparam int unsigned MAX_IDXW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } victim_state_e;

  // Returns {inv_sel, cand}: prefer invalid+unlocked ways, else any unlocked way.
  function automatic logic [MAX_WAYS:0] cand_mask(input logic [MAX_WAYS-1:0] valid,
                                                   input logic [MAX_WAYS-1:0] lock);
    logic [MAX_WAYS-1:0] inv_free;
    inv_free = ~valid & ~lock;
    if (inv_free != '0) cand_mask = {1'b1, inv_free};
    else                cand_mask = {1'b0, ~lock};
  endfunction

endpackage

// File: rtl/cmn_rand_victim_sel.sv
// Random-replacement victim picker: round-robin scan from an LFSR start way,
// invalid+unlocked ways first, else any unlocked way; valid/ready on both sides.
module cmn_rand_victim_sel
  import cmn_rand_pkg::*;
#(
  parameter int unsigned WAYS = 8,
  localparam int unsigned IDXW = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      rand_i,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic [WAYS-1:0] valid_mask,
  input  logic [WAYS-1:0] lock_mask,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [IDXW-1:0] rsp_way,
  output logic            rsp_inv,
  output logic            rsp_none
);

  victim_state_e       state_q;
  logic [IDXW-1:0]     ptr_q;
  logic [MAX_WAYS-1:0] cand_q;
  logic                inv_sel_q;
  logic                req_rdy_q;
  logic                rsp_vld_q;
  logic [IDXW-1:0]     rsp_way_q;
  logic                rsp_inv_q;
  logic                rsp_none_q;

  logic [MAX_WAYS-1:0] valid_ext_c;
  logic [MAX_WAYS-1:0] lock_ext_c;
  logic [MAX_WAYS:0]   sel_c;
  logic                all_locked_c;

  // Pad unused upper ways as valid+locked so they can never be candidates.
  always_comb begin
    valid_ext_c                = '1;
    lock_ext_c                 = '1;
    valid_ext_c[WAYS-1:0]      = valid_mask;
    lock_ext_c[WAYS-1:0]       = lock_mask;
    sel_c                      = cand_mask(valid_ext_c, lock_ext_c);
    all_locked_c               = (~lock_mask == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cand_q     <= '0;
      inv_sel_q  <= 1'b0;
      req_rdy_q  <= 1'b1;
      rsp_vld_q  <= 1'b0;
      rsp_way_q  <= '0;
      rsp_inv_q  <= 1'b0;
      rsp_none_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_vld && req_rdy_q) begin
            cand_q    <= sel_c[MAX_WAYS-1:0];
            inv_sel_q <= sel_c[MAX_WAYS];
            ptr_q     <= IDXW'(rand_i);
            req_rdy_q <= 1'b0;
            if (all_locked_c) begin
              state_q    <= RESP;
              rsp_vld_q  <= 1'b1;
              rsp_way_q  <= '0;
              rsp_inv_q  <= 1'b0;
              rsp_none_q <= 1'b1;
            end else begin
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          // One way tested per cycle; the pointer wraps naturally at WAYS.
          if (cand_q[MAX_IDXW'(ptr_q)]) begin
            state_q    <= RESP;
            rsp_vld_q  <= 1'b1;
            rsp_way_q  <= ptr_q;
            rsp_inv_q  <= inv_sel_q;
            rsp_none_q <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_rdy) begin
            state_q   <= IDLE;
            rsp_vld_q <= 1'b0;
            req_rdy_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          rsp_vld_q <= 1'b0;
          req_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_rdy  = req_rdy_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_way  = rsp_way_q;
  assign rsp_inv  = rsp_inv_q;
  assign rsp_none = rsp_none_q;

endmodule
